// File: rtl/main_pkg.sv
// Shared constants and types for the keyboard note engine.
// Button rise vectors are packed b1 (MSB) down to b5 (LSB).
package main_pkg;

    localparam int unsigned W    = 27;
    localparam int unsigned TMAX = 12;

    typedef logic signed [4:0] trans_t;

    typedef struct packed {
        logic inc;
        logic dec;
        logic zero;
        logic hold;
        logic panic;
    } btn_t;

    // Zero beats inc/dec; inc and dec together cancel; both directions saturate at +/-lim.
    function automatic trans_t trans_next(input trans_t t, input btn_t r, input trans_t lim);
        trans_t n;
        n = t;
        if (r.zero) begin
            n = '0;
        end else if (r.inc && !r.dec) begin
            n = (t >= lim) ? t : t + trans_t'(1);
        end else if (r.dec && !r.inc) begin
            n = (t <= -lim) ? t : t - trans_t'(1);
        end
        return n;
    endfunction

    // Magnitude of a transpose value as an unsigned shift amount.
    function automatic logic [4:0] trans_mag(input trans_t t);
        logic [4:0] m;
        m = t[4] ? -t : t;
        return m;
    endfunction

endpackage

// File: rtl/main_core_sync_edge.sv
// Parameterized 2-flop synchronizer with optional rising-edge detection.
// With EDGE=0 the previous-value register is omitted and rise_o is tied low.
module sync_edge
    import main_pkg::*;
#(
    parameter int unsigned N    = 1,
    parameter bit          EDGE = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] sync_o,
    output logic [N-1:0] rise_o
);

    logic [N-1:0] meta_q;
    logic [N-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

    generate
        if (EDGE) begin : g_edge
            logic [N-1:0] prev_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    prev_q <= '0;
                end else begin
                    prev_q <= sync_q;
                end
            end

            assign rise_o = sync_q & ~prev_q;
        end else begin : g_no_edge
            assign rise_o = '0;
        end
    endgenerate

endmodule

// File: rtl/main_core.sv
// Note engine: synchronizes keys/buttons, applies latch, hold and transpose,
// and registers the resulting note-on vector for the tone generators.
module main_core #(
    parameter int unsigned W    = main_pkg::W,
    parameter int unsigned TMAX = main_pkg::TMAX
) (
    input  logic         clk,
    input  logic         reset,
    output logic [W-1:0] note,
    input  logic [W-1:0] key,
    input  logic         b1,
    input  logic         b2,
    input  logic         b3,
    input  logic         b4,
    input  logic         b5,
    input  logic         sw1
);

    import main_pkg::*;

    localparam trans_t TPOS = trans_t'(TMAX);

    logic [W-1:0] key_sync;
    logic [W-1:0] key_rise;
    logic [4:0]   btn_sync_unused;
    logic [4:0]   btn_rise_raw;
    logic         sw1_sync;
    logic         sw1_rise_unused;
    btn_t         btn_rise;

    trans_t       t_q, t_d;
    logic [W-1:0] lat_q, lat_d;
    logic         hold_q, hold_d;
    logic [W-1:0] note_q, note_d;

    logic [W-1:0] base;
    logic [W-1:0] shifted;
    logic [4:0]   shamt;

    sync_edge #(
        .N    (W),
        .EDGE (1'b1)
    ) u_key_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (key),
        .sync_o (key_sync),
        .rise_o (key_rise)
    );

    sync_edge #(
        .N    (5),
        .EDGE (1'b1)
    ) u_btn_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    ({b1, b2, b3, b4, b5}),
        .sync_o (btn_sync_unused),
        .rise_o (btn_rise_raw)
    );

    sync_edge #(
        .N    (1),
        .EDGE (1'b0)
    ) u_sw1_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (sw1),
        .sync_o (sw1_sync),
        .rise_o (sw1_rise_unused)
    );

    assign btn_rise = btn_t'(btn_rise_raw);

    always_comb begin
        t_d = trans_next(t_q, btn_rise, TPOS);
    end

    // Panic outranks both key toggles and a simultaneous hold toggle.
    always_comb begin
        lat_d  = lat_q;
        hold_d = hold_q;
        if (btn_rise.panic) begin
            lat_d  = '0;
            hold_d = 1'b0;
        end else begin
            if (sw1_sync) begin
                lat_d = lat_q ^ key_rise;
            end
            if (btn_rise.hold) begin
                hold_d = ~hold_q;
            end
        end
    end

    always_comb begin
        base    = sw1_sync ? lat_q : key_sync;
        shamt   = trans_mag(t_q);
        shifted = t_q[4] ? (base >> shamt) : (base << shamt);
        note_d  = hold_q ? note_q : shifted;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_q    <= '0;
            lat_q  <= '0;
            hold_q <= 1'b0;
            note_q <= '0;
        end else begin
            t_q    <= t_d;
            lat_q  <= lat_d;
            hold_q <= hold_d;
            note_q <= note_d;
        end
    end

    assign note = note_q;

endmodule

// File: tb/tb_main_core.sv
// Self-checking bench for main_core: directed vector table, hand sequences,
// button sweep and randomized traffic against a delay-line behavioural model.
module tb_main_core;

    localparam int unsigned NW = 27;

    localparam logic [4:0] B1 = 5'b10000;
    localparam logic [4:0] B2 = 5'b01000;
    localparam logic [4:0] B3 = 5'b00100;
    localparam logic [4:0] B4 = 5'b00010;
    localparam logic [4:0] B5 = 5'b00001;

    typedef struct packed {
        logic [NW-1:0] key;
        logic [4:0]    b;
        logic          sw1;
    } in_t;

    typedef struct {
        in_t           in;
        int unsigned   n;
        bit            chk;
        logic [NW-1:0] exp;
        string         name;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NW-1:0] key = '0;
    logic          b1 = 1'b0, b2 = 1'b0, b3 = 1'b0, b4 = 1'b0, b5 = 1'b0;
    logic          sw1 = 1'b0;
    logic [NW-1:0] note;

    int checks = 0;
    int failures = 0;

    // Behavioural model state: inputs seen 1, 2, 3 edges ago and engine state.
    in_t           h1, h2, h3;
    int            m_t;
    logic [NW-1:0] m_lat;
    logic          m_hold;
    logic [NW-1:0] m_note;

    vec_t vecs[$];

    main_core #(
        .W    (NW),
        .TMAX (12)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .note  (note),
        .key   (key),
        .b1    (b1),
        .b2    (b2),
        .b3    (b3),
        .b4    (b4),
        .b5    (b5),
        .sw1   (sw1)
    );

    always #5 clk = ~clk;

    function automatic in_t mk(input logic [NW-1:0] kk, input logic [4:0] bb, input logic ss);
        in_t v;
        v.key = kk;
        v.b   = bb;
        v.sw1 = ss;
        return v;
    endfunction

    function automatic logic [NW-1:0] bit_n(input int unsigned n);
        logic [NW-1:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: note=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input in_t v);
        key = v.key;
        {b1, b2, b3, b4, b5} = v.b;
        sw1 = v.sw1;
    endtask

    task automatic model_reset();
        h1 = '0;
        h2 = '0;
        h3 = '0;
        m_t = 0;
        m_lat = '0;
        m_hold = 1'b0;
        m_note = '0;
    endtask

    // One clock edge: the engine sees inputs from two edges ago, rises against three edges ago.
    task automatic model_edge();
        logic [4:0]    r;
        logic [NW-1:0] kr, base, sh;
        r  = h2.b & ~h3.b;
        kr = h2.key & ~h3.key;
        base = h2.sw1 ? m_lat : h2.key;
        if (m_t >= 0) sh = base << m_t;
        else          sh = base >> (-m_t);
        if (!m_hold) m_note = sh;
        if (r[2])                m_t = 0;
        else if (r[4] && r[3])   m_t = m_t;
        else if (r[4])           m_t = (m_t + 1 > 12) ? 12 : m_t + 1;
        else if (r[3])           m_t = (m_t - 1 < -12) ? -12 : m_t - 1;
        if (r[0]) begin
            m_lat  = '0;
            m_hold = 1'b0;
        end else begin
            if (h2.sw1) m_lat = m_lat ^ kr;
            if (r[1])   m_hold = ~m_hold;
        end
    endtask

    task automatic tick(input in_t v);
        apply(v);
        @(posedge clk);
        model_edge();
        h3 = h2;
        h2 = h1;
        h1 = v;
        #1;
        check("model", note, m_note);
    endtask

    task automatic step(input logic [NW-1:0] kk, input logic [4:0] bb, input logic ss,
                        input int unsigned n, input bit chk, input logic [NW-1:0] exp,
                        input string name);
        repeat (n) tick(mk(kk, bb, ss));
        if (chk) check(name, note, exp);
    endtask

    task automatic pulse(input logic [NW-1:0] kk, input logic [4:0] bb, input logic ss);
        tick(mk(kk, bb, ss));
        tick(mk(kk, 5'b0, ss));
    endtask

    function automatic void addv(input logic [NW-1:0] kk, input logic [4:0] bb, input logic ss,
                                 input int unsigned n, input bit chk, input logic [NW-1:0] exp,
                                 input string name);
        vec_t v;
        v.in   = mk(kk, bb, ss);
        v.n    = n;
        v.chk  = chk;
        v.exp  = exp;
        v.name = name;
        vecs.push_back(v);
    endfunction

    initial begin
        in_t rv;

        // Live pass-through and its latency
        addv(bit_n(0),  5'b0, 1'b0, 2, 1'b1, '0,        "live_lat2");
        addv(bit_n(0),  5'b0, 1'b0, 1, 1'b1, bit_n(0),  "live_on");
        addv('0,        5'b0, 1'b0, 2, 1'b1, bit_n(0),  "live_off_lat2");
        addv('0,        5'b0, 1'b0, 1, 1'b1, '0,        "live_off");
        // Three +1 pulses
        for (int i = 0; i < 3; i++) begin
            addv(bit_n(0), B1,   1'b0, 1, 1'b0, '0, "");
            addv(bit_n(0), 5'b0, 1'b0, 1, 1'b0, '0, "");
        end
        addv(bit_n(0),  5'b0, 1'b0, 4, 1'b1, bit_n(3),  "tp_up3");
        addv(bit_n(26), 5'b0, 1'b0, 4, 1'b1, '0,        "tp_discard_hi");
        addv(bit_n(23), 5'b0, 1'b0, 4, 1'b1, bit_n(26), "tp_top_edge");
        addv(bit_n(26), B3,   1'b0, 1, 1'b0, '0,        "");
        addv(bit_n(26), 5'b0, 1'b0, 4, 1'b1, bit_n(26), "tp_zero");
        addv(bit_n(26), B1|B2, 1'b0, 1, 1'b0, '0,       "");
        addv(bit_n(26), 5'b0, 1'b0, 4, 1'b1, bit_n(26), "tp_both");
        for (int i = 0; i < 2; i++) begin
            addv(bit_n(26), B1,   1'b0, 1, 1'b0, '0, "");
            addv(bit_n(26), 5'b0, 1'b0, 1, 1'b0, '0, "");
        end
        addv(bit_n(26), 5'b0, 1'b0, 4, 1'b1, '0,        "discard_p2");
        addv(bit_n(0),  5'b0, 1'b0, 4, 1'b1, bit_n(2),  "shift_p2");
        addv('0,        B3,   1'b0, 1, 1'b0, '0,        "");
        addv('0,        5'b0, 1'b0, 4, 1'b1, '0,        "back_zero");

        // Reset with random inputs
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            apply(mk(NW'($urandom), 5'($urandom), 1'($urandom)));
            @(posedge clk);
            #1;
            check("reset_hold", note, '0);
        end
        apply(mk('0, 5'b0, 1'b0));
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(mk('0, 5'b0, 1'b0));
            check("reset_release", note, '0);
        end

        foreach (vecs[i]) begin
            step(vecs[i].in.key, vecs[i].in.b, vecs[i].in.sw1, vecs[i].n,
                 vecs[i].chk, vecs[i].exp, vecs[i].name);
        end

        // Saturation at both ends
        for (int i = 0; i < 20; i++) pulse('0, B2, 1'b0);
        step(bit_n(26), 5'b0, 1'b0, 4, 1'b1, bit_n(14), "sat_neg");
        step(bit_n(11), 5'b0, 1'b0, 4, 1'b1, '0,        "neg_discard");
        pulse(bit_n(26), B3, 1'b0);
        step(bit_n(26), 5'b0, 1'b0, 4, 1'b1, bit_n(26), "tp_zero2");
        for (int i = 0; i < 20; i++) pulse('0, B1, 1'b0);
        step(bit_n(0),  5'b0, 1'b0, 4, 1'b1, bit_n(12), "sat_pos");
        pulse('0, B3, 1'b0);
        step('0, 5'b0, 1'b0, 4, 1'b1, '0, "zero_again");

        // Latch mode
        step('0,       5'b0, 1'b1, 4, 1'b1, '0,       "latch_empty");
        step(bit_n(5), 5'b0, 1'b1, 3, 1'b1, '0,       "latch_lat3");
        step(bit_n(5), 5'b0, 1'b1, 1, 1'b1, bit_n(5), "latch_lat4");
        step('0,       5'b0, 1'b1, 4, 1'b1, bit_n(5), "latch_persist");
        step(bit_n(5), 5'b0, 1'b1, 2, 1'b0, '0,       "");
        step('0,       5'b0, 1'b1, 4, 1'b1, '0,       "latch_clear");
        step(bit_n(5), 5'b0, 1'b1, 2, 1'b0, '0,       "");
        step('0,       5'b0, 1'b1, 4, 1'b1, bit_n(5), "latch_reset");
        step(bit_n(9), 5'b0, 1'b0, 4, 1'b1, bit_n(9), "mode_live");
        step(bit_n(9), 5'b0, 1'b1, 4, 1'b1, bit_n(5), "mode_latch");
        step('0,       5'b0, 1'b1, 2, 1'b0, '0,       "");

        // Hold and panic
        step(bit_n(7), 5'b0, 1'b0, 4, 1'b1, bit_n(7), "pre_hold");
        step(bit_n(7), B4,   1'b0, 1, 1'b0, '0,       "");
        step(bit_n(3), 5'b0, 1'b0, 6, 1'b1, bit_n(7), "hold_frozen");
        step(bit_n(3), B5,   1'b0, 1, 1'b0, '0,       "");
        step(bit_n(3), 5'b0, 1'b0, 5, 1'b1, bit_n(3), "panic_live");
        step('0,       5'b0, 1'b1, 5, 1'b1, '0,       "panic_lat_clr");
        step('0,       5'b0, 1'b0, 4, 1'b1, '0,       "pre_sweep");

        // Button sweep with no keys
        for (int c = 0; c < 32; c++) begin
            repeat (50) begin
                tick(mk('0, 5'(c), 1'b0));
                check("sweep_zero", note, '0);
            end
        end
        pulse('0, B5, 1'b0);
        step('0, 5'b0, 1'b0, 4, 1'b1, '0, "post_sweep");

        // Randomized traffic
        rv = mk('0, 5'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) rv.key = NW'($urandom) & NW'($urandom);
            for (int j = 0; j < 5; j++) rv.b[j] = ($urandom_range(15) == 0);
            if ($urandom_range(63) == 0) rv.sw1 = ~rv.sw1;
            tick(rv);
        end

        // Asynchronous reset in mid-operation
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check("async_reset", note, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 check("reset_held", note, '0);
        apply(mk('0, 5'b0, 1'b0));
        reset = 1'b1;
        step(bit_n(0), 5'b0, 1'b0, 3, 1'b1, bit_n(0), "post_reset_live");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/main_core.md
# main_core

Top-level note engine for the keyboard instrument (module `main`). It samples 27 piano-key inputs and five push-buttons, then applies latch mode, hold and transposition. It drives a registered 27-bit note vector to the downstream tone generators, one bit per semitone with bit 0 the lowest. It is the root control block; all inputs are asynchronous to `clk` and are synchronized internally.

## Interface
- `W`, default 27: number of keys/notes.
- `TMAX`, default 12: maximum transpose magnitude in semitones.
- `clk`, input, 1: system clock, all logic on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `note`, output, W: registered note-on vector.
- `key`, input, W: raw key levels, 1 = pressed.
- `b1`, input, 1: transpose +1.
- `b2`, input, 1: transpose −1.
- `b3`, input, 1: transpose to 0.
- `b4`, input, 1: toggle hold.
- `b5`, input, 1: panic (clear latch and hold).
- `sw1`, input, 1: mode select; 0 = live, 1 = latch.

## Operation
- Input synchronization:
  - `key`, `b1..b5` and `sw1` each pass through a 2-flop synchronizer.
  - `key` and `b1..b5` additionally keep a previous-value register for rising-edge detection: `rise = sync & ~prev`.
- Transpose register `t`:
  - Signed 5-bit, range −TMAX..+TMAX.
  - `b1` rise: `t+1`, saturating at +TMAX.
  - `b2` rise: `t−1`, saturating at −TMAX.
  - `b1` and `b2` rising in the same cycle: `t` unchanged.
  - `b3` rise: `t=0`; this overrides `b1`/`b2` in the same cycle.
- Latch register `lat[W-1:0]`:
  - When synchronized `sw1`=1, each key rise toggles `lat[i]`.
  - When `sw1`=0, `lat` holds its value.
- Hold flag `hold`: a `b4` rise toggles it.
- Panic: a `b5` rise clears `lat` to 0 and `hold` to 0. This wins over key toggles and over a `b4` rise in the same cycle. `t` is unaffected.
- Base vector: `base = sw1_sync ? lat : key_sync`.
- Shift:
  - `t > 0`: `base << t`.
  - `t < 0`: `base >> |t|`.
  - Bits shifted past either end are discarded; vacated bits are 0.
- Output:
  - When `hold`=0, `note` ← the shifted vector every cycle.
  - When `hold`=1, `note` keeps its value. Panic releases hold, and the output resumes on the next cycle.
- Mode switch: changing `sw1` takes effect on the base selection with no clearing of `lat`.

## Timing
- Reset (`reset`=0, asynchronous) clears all state:
  - `note`, `t`, `lat`, `hold` = 0.
  - All synchronizer and previous-value flops = 0.
  - Release is synchronous to the next `clk` edge via the design's normal flops; no reset synchronizer is required inside this block.
  - Reset asserted mid-operation clears everything immediately.
- Live-mode key latency: a key level change appears on `note` 3 rising edges after the input changes (2 sync flops + output register).
- Button latency: the button changes, `t`/`hold`/`lat` updates on the 3rd edge, and `note` reflects it on the 4th edge.
- Latch toggle latency: a key press in latch mode appears on `note` on the 4th edge.
- An input held high produces exactly one rise, so one action per press. No debounce is performed here; the board supplies debounced buttons.

## Structure
- Shared package `main_pkg`: `W`, `TMAX`, and the transpose type (`logic signed [4:0]`).
- One natural sub-module, `sync_edge`: a parameterized-width 2-flop synchronizer with rising-edge output, instantiated for `key` (W) and for `b1..b5` (5 bits).
- `sw1` uses the same sync without the edge output.

## Test plan
- Reset: hold `reset`=0 for 10 cycles with random inputs → `note`=0; release, all inputs 0 → `note` stays 0.
- Live pass-through: `sw1`=0, `key`=27'h0000_0001 → `note`=27'h0000_0001 on the 3rd edge; `key`=0 → `note` returns to 0 after 3 edges.
- Transpose:
  - Three `b1` pulses with `key`=bit0 → `note`=bit3.
  - Then 20 `b2` pulses → `t` saturates at −12, and `key`=bit26 gives `note`=bit14.
  - `b3` → `note`=bit26.
  - `b1` and `b2` rising together → no change.
- Edge discard: `t`=+2, `key`=bit26 → `note`=0.
- Latch mode: `sw1`=1, press and release key 5 → `note[5]`=1 persists; a second press → `note[5]`=0. Switching `sw1`=0 shows the live keys; switching back restores the latched bit 5.
- Hold and panic:
  - `note`=bit7, `b4` pulse, change keys → `note` frozen at bit7.
  - `b5` pulse → `hold` cleared, `lat`=0, and `note` tracks the live keys again.
- Sweep: drive `b1..b5` with all 32 combinations, 50 cycles each, `key`=0 → `note` never nonzero; `t` stays within ±12.
